// File: rtl/rangos_n_hist_pkg.sv
// Shared types and helpers for the rangos_n_hist temperature-band classifier.
package rangos_n_hist_pkg;

    // Classifier operating phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    // Highest base that still keeps the top threshold inside the sample range.
    function automatic int unsigned bmax_f(input int unsigned temp_w,
                                           input int unsigned n_ranges,
                                           input int unsigned span);
        return (32'd1 << temp_w) - 32'd1 - ((n_ranges - 32'd1) * span);
    endfunction

endpackage

// File: rtl/rangos_n_hist_flanco_pulso.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high transition.
module rangos_n_hist_flanco_pulso (
    input  logic clk,
    input  logic rst,
    input  logic i_lvl,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    // Remember the previous level and flag a rising transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_lvl;
            r_pulse <= i_lvl & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/rangos_n_hist.sv
// Temperature band classifier with downward hysteresis and adjustable base.
module rangos_n_hist
    import rangos_n_hist_pkg::*;
#(
    parameter int unsigned TEMP_W   = 5,
    parameter int unsigned N_RANGES = 4,
    parameter int unsigned SPAN     = 5,
    parameter int unsigned HYST     = 1,
    parameter int unsigned STEP     = 1,
    parameter int unsigned BASE_RST = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          lect,
    input  logic [TEMP_W-1:0]             temperatura,
    input  logic                          load,
    input  logic [TEMP_W-1:0]             base_in,
    input  logic                          cup,
    input  logic                          cdown,
    output logic [$clog2(N_RANGES)-1:0]   rango,
    output logic                          rango_ok,
    output logic                          cambio,
    output logic [TEMP_W-1:0]             base
);

    localparam int unsigned RW   = $clog2(N_RANGES);
    localparam int unsigned XW   = TEMP_W + RW + 1;
    localparam int unsigned BMAX = bmax_f(TEMP_W, N_RANGES, SPAN);

    state_t              r_state;
    logic [RW-1:0]       r_rango;
    logic                r_ok;
    logic                r_cambio;
    logic [TEMP_W-1:0]   r_base;

    logic                w_cup_p;
    logic                w_cdn_p;
    logic [TEMP_W-1:0]   w_base_nxt;
    logic [XW-1:0]       w_base_x;
    logic [XW-1:0]       w_temp_x;
    logic [XW-1:0]       w_thr_i;
    logic [N_RANGES-1:1] w_ge;
    logic [RW-1:0]       w_plain;
    logic                w_up;
    logic                w_down;

    rangos_n_hist_flanco_pulso u_edge_up (
        .clk     (clk),
        .rst     (rst),
        .i_lvl   (cup),
        .o_pulse (w_cup_p)
    );

    rangos_n_hist_flanco_pulso u_edge_dn (
        .clk     (clk),
        .rst     (rst),
        .i_lvl   (cdown),
        .o_pulse (w_cdn_p)
    );

    assign w_base_x = XW'(r_base);
    assign w_temp_x = XW'(temperatura);

    // One comparator per threshold T_k = base + k*SPAN.
    for (genvar k = 1; k < N_RANGES; k++) begin : g_thr
        assign w_ge[k] = (w_temp_x >= (w_base_x + XW'(k * SPAN)));
    end

    // Plain class: number of thresholds reached by the sample.
    always_comb begin
        w_plain = '0;
        for (int unsigned k = 1; k < N_RANGES; k++) begin
            w_plain = w_plain + RW'(w_ge[k]);
        end
    end

    // Upward move when the next threshold above the current band is reached.
    always_comb begin
        w_up = 1'b0;
        for (int unsigned k = 1; k < N_RANGES; k++) begin
            if (RW'(k - 1) == r_rango) begin
                w_up = w_ge[k];
            end
        end
    end

    // Downward move only below T_i - HYST; a negative bound never triggers.
    always_comb begin
        w_thr_i = w_base_x + (XW'(r_rango) * XW'(SPAN));
        w_down  = (r_rango != '0) &&
                  (w_thr_i >= XW'(HYST)) &&
                  (w_temp_x < (w_thr_i - XW'(HYST)));
    end

    // Next base: load wins over button steps; both buttons together cancel.
    always_comb begin
        w_base_nxt = r_base;
        if (load) begin
            w_base_nxt = (XW'(base_in) > XW'(BMAX)) ? TEMP_W'(BMAX) : base_in;
        end else if (w_cup_p && !w_cdn_p) begin
            w_base_nxt = ((w_base_x + XW'(STEP)) > XW'(BMAX)) ?
                         TEMP_W'(BMAX) : TEMP_W'(w_base_x + XW'(STEP));
        end else if (w_cdn_p && !w_cup_p) begin
            w_base_nxt = (w_base_x < XW'(STEP)) ?
                         '0 : TEMP_W'(w_base_x - XW'(STEP));
        end
    end

    // Base register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= TEMP_W'(BASE_RST);
        end else begin
            r_base <= w_base_nxt;
        end
    end

    // Classifier FSM with registered band, valid flag and change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rango  <= '0;
            r_ok     <= 1'b0;
            r_cambio <= 1'b0;
        end else begin
            r_cambio <= 1'b0;
            if (!en) begin
                r_state <= ST_IDLE;
                r_rango <= '0;
                r_ok    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ACQ;
                        r_rango <= '0;
                        r_ok    <= 1'b0;
                    end
                    ST_ACQ: begin
                        if (lect) begin
                            r_rango  <= w_plain;
                            r_ok     <= 1'b1;
                            r_cambio <= 1'b1;
                            r_state  <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (lect && (w_up || w_down)) begin
                            r_rango  <= w_plain;
                            r_cambio <= (w_plain != r_rango);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rango    = r_rango;
    assign rango_ok = r_ok;
    assign cambio   = r_cambio;
    assign base     = r_base;

endmodule
